// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports plus the registered single-port memory bus.
// The arbiter takes the slave side; requesters and the memory sit on the master side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_wen;
  logic [31:0] mem_dout;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_addr, mem_din, mem_wen
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_addr, mem_din, mem_wen
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory between fetch and load/store: grant in IDLE, one access cycle, rvalid 2 edges after accept.
// Requests wait (gnt low) while an access is in flight; D wins ties until its streak reaches MAX_D_STREAK.
module mem_port_arbiter #(
  parameter int DEPTH        = 32,
  parameter int MAX_D_STREAK = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  MAX_W   = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D} state_t;

  state_t      state;
  logic [3:0]  d_streak;
  logic        store_q;
  logic        oor_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_din_q;
  logic        mem_wen_q;
  logic        if_rvalid_q;
  logic [31:0] if_rdata_q;
  logic        if_err_q;
  logic        d_rvalid_q;
  logic [31:0] d_rdata_q;
  logic        d_err_q;

  logic force_if;
  logic d_gnt_c;
  logic if_gnt_c;
  logic d_oor;
  logic if_oor;

  always_comb begin
    force_if = bus.if_req && (d_streak == MAX_W);
    d_gnt_c  = rst && (state == IDLE) && bus.d_req && !force_if;
    if_gnt_c = rst && (state == IDLE) && bus.if_req && !d_gnt_c;
    d_oor    = bus.d_addr >= DEPTH_W;
    if_oor   = bus.if_addr >= DEPTH_W;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      d_streak    <= '0;
      store_q     <= 1'b0;
      oor_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wen_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_gnt_c) begin
            mem_addr_q <= bus.d_addr;
            mem_din_q  <= bus.d_wdata;
            store_q    <= bus.d_we;
            oor_q      <= d_oor;
            // Write strobe is decided here so it is a clean flop during ACC_D.
            mem_wen_q  <= bus.d_we && !d_oor;
            state      <= ACC_D;
            if (bus.if_req)
              d_streak <= (d_streak >= MAX_W) ? MAX_W : d_streak + 4'd1;
            else
              d_streak <= '0;
          end else if (if_gnt_c) begin
            mem_addr_q <= bus.if_addr;
            mem_din_q  <= '0;
            store_q    <= 1'b0;
            oor_q      <= if_oor;
            mem_wen_q  <= 1'b0;
            state      <= ACC_IF;
            d_streak   <= '0;
          end
        end
        ACC_IF: begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= oor_q ? '0 : bus.mem_dout;
          if_err_q    <= oor_q;
          mem_wen_q   <= 1'b0;
          state       <= IDLE;
        end
        ACC_D: begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= (store_q || oor_q) ? '0 : bus.mem_dout;
          d_err_q    <= oor_q;
          mem_wen_q  <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          mem_wen_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: grants push expected responses into per-port queues,
// rvalid pulses pop and compare them; scenario tasks check grant timing and memory writes.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  mem_port_arbiter_if b();

  mem_port_arbiter #(.DEPTH(32), .MAX_D_STREAK(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  bit          gnt_log[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wen_count = 0;
  logic [31:0] wen_addr;
  logic [31:0] wen_din;
  logic [31:0] mem [0:31];
  logic [31:0] model [0:31];
  bit          mem_ready;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h00200513 : (32'hC0DE0000 | 32'(i));
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Memory model: combinational read, out-of-range reads return junk the DUT must mask.
  assign b.mem_dout = (b.mem_addr < 32) ? mem[b.mem_addr[4:0]] : 32'hBADBAD00;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (b.mem_wen && b.mem_addr < 32) begin
      mem[b.mem_addr[4:0]] <= b.mem_din;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (b.mem_wen) begin
        wen_count++;
        wen_addr = b.mem_addr;
        wen_din  = b.mem_din;
      end
      if (b.if_rvalid) begin
        n_chk++;
        if (if_q.size() == 0) begin
          n_fail++;
          $display("FAIL if_unexpected_rvalid: got rvalid 1, required no pending fetch");
        end else begin
          e = if_q.pop_front();
          if ({b.if_rdata, b.if_err} !== {e.rdata, e.err}) begin
            n_fail++;
            $display("FAIL if_resp: got %h/%b, required %h/%b", b.if_rdata, b.if_err, e.rdata, e.err);
          end
          n_chk++;
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL if_latency: got cycle %0d, required %0d", cyc, e.cyc);
          end
        end
      end
      if (b.d_rvalid) begin
        n_chk++;
        if (d_q.size() == 0) begin
          n_fail++;
          $display("FAIL d_unexpected_rvalid: got rvalid 1, required no pending data access");
        end else begin
          e = d_q.pop_front();
          if ({b.d_rdata, b.d_err} !== {e.rdata, e.err}) begin
            n_fail++;
            $display("FAIL d_resp: got %h/%b, required %h/%b", b.d_rdata, b.d_err, e.rdata, e.err);
          end
          n_chk++;
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL d_latency: got cycle %0d, required %0d", cyc, e.cyc);
          end
          if (e.st && !e.err) model[e.addr[4:0]] = e.wdata;
        end
      end
      if (b.if_gnt && b.d_gnt) begin
        n_chk++;
        n_fail++;
        $display("FAIL dual_grant: got both gnt, required one");
      end
      if (b.d_gnt) begin
        e.st    = b.d_we;
        e.addr  = b.d_addr;
        e.wdata = b.d_wdata;
        e.err   = (b.d_addr >= 32);
        e.rdata = (b.d_we || e.err) ? 32'h0 : model[b.d_addr[4:0]];
        e.cyc   = cyc + 2;
        d_q.push_back(e);
        gnt_log.push_back(1'b1);
      end
      if (b.if_gnt) begin
        e.st    = 1'b0;
        e.addr  = b.if_addr;
        e.wdata = 32'h0;
        e.err   = (b.if_addr >= 32);
        e.rdata = e.err ? 32'h0 : model[b.if_addr[4:0]];
        e.cyc   = cyc + 2;
        if_q.push_back(e);
        gnt_log.push_back(1'b0);
      end
    end
  end

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd, output int n);
    @(posedge clk); #1;
    b.d_req = 1'b1; b.d_we = we; b.d_addr = a; b.d_wdata = wd;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b.d_gnt) break;
    end
    @(posedge clk); #1;
    b.d_req = 1'b0;
  endtask

  task automatic req_if(input logic [31:0] a, output int n);
    @(posedge clk); #1;
    b.if_req = 1'b1; b.if_addr = a;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b.if_gnt) break;
    end
    @(posedge clk); #1;
    b.if_req = 1'b0;
  endtask

  task automatic drain(output bit ok);
    for (int i = 0; i < 40 && (if_q.size() != 0 || d_q.size() != 0); i++) @(negedge clk);
    ok = (if_q.size() == 0 && d_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    b.if_req = 1'b1; b.if_addr = 0;
    b.d_req = 1'b1; b.d_we = 1'b1; b.d_addr = 0; b.d_wdata = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({b.if_gnt, b.d_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b, required 00", {b.if_gnt, b.d_gnt});
    end
    n_chk++;
    if ({b.if_rvalid, b.d_rvalid, b.if_err, b.d_err, b.mem_wen} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 00000", {b.if_rvalid, b.d_rvalid, b.if_err, b.d_err, b.mem_wen});
    end
    n_chk++;
    if ({b.if_rdata, b.d_rdata, b.mem_addr, b.mem_din} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h, required 0", b.if_rdata, b.d_rdata, b.mem_addr, b.mem_din);
    end
    b.if_req = 1'b0; b.d_req = 1'b0; b.d_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lone_fetch;
    int n; bit ok; int w0;
    w0 = wen_count;
    req_if(32'h0, n);
    n_chk++;
    if (n != 0) begin
      n_fail++; $display("FAIL fetch_gnt_same_cycle: got wait %0d, required 0", n);
    end
    drain(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL fetch_drain: got pending, required empty"); end
    n_chk++;
    if (wen_count != w0) begin
      n_fail++; $display("FAIL fetch_no_write: got %0d writes, required 0", wen_count - w0);
    end
  endtask

  task automatic test_store_load;
    int n; bit ok; int w0;
    w0 = wen_count;
    req_d(1'b1, 32'd5, 32'hDEADBEEF, n);
    n_chk++;
    if ({b.mem_wen, b.mem_addr, b.mem_din} !== {1'b1, 32'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL store_acc: got wen %b addr %h din %h, required 1 5 deadbeef", b.mem_wen, b.mem_addr, b.mem_din);
    end
    drain(ok);
    n_chk++;
    if (wen_count != w0 + 1 || wen_addr !== 32'd5) begin
      n_fail++; $display("FAIL store_wen_pulse: got %0d pulses addr %h, required 1 at 5", wen_count - w0, wen_addr);
    end
    req_d(1'b0, 32'd5, 32'h0, n);
    drain(ok);
    repeat (3) @(negedge clk);
    n_chk++;
    if (b.d_rdata !== 32'hDEADBEEF || !ok) begin
      n_fail++; $display("FAIL load_hold: got %h, required deadbeef", b.d_rdata);
    end
  endtask

  task automatic test_fairness;
    bit [9:0] got, want;
    @(posedge clk); #1;
    gnt_log.delete();
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 32'd1;
    b.if_req = 1'b1; b.if_addr = 32'd2;
    for (int i = 0; i < 80 && gnt_log.size() < 10; i++) @(posedge clk);
    #1;
    b.d_req = 1'b0; b.if_req = 1'b0;
    got = '0; want = '0;
    for (int i = 0; i < 10; i++) begin
      want[9-i] = (i % 5) != 4;
      if (i < gnt_log.size()) got[9-i] = gnt_log[i];
    end
    n_chk++;
    if (gnt_log.size() < 10 || got !== want) begin
      n_fail++; $display("FAIL fairness_order: got %b (%0d grants), required %b", got, gnt_log.size(), want);
    end
  endtask

  task automatic test_out_of_range;
    int n; bit ok; int w0;
    w0 = wen_count;
    req_d(1'b1, 32'd32, 32'hCAFEF00D, n);
    drain(ok);
    n_chk++;
    if (wen_count != w0) begin
      n_fail++; $display("FAIL oor_store_write: got %0d pulses, required 0", wen_count - w0);
    end
    n_chk++;
    if (b.d_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_d_err_hold: got %b, required 1", b.d_err);
    end
    req_if(32'hFFFFFFFF, n);
    n_chk++;
    if (b.mem_addr !== 32'hFFFFFFFF || b.mem_wen !== 1'b0) begin
      n_fail++; $display("FAIL oor_fetch_addr: got %h wen %b, required ffffffff 0", b.mem_addr, b.mem_wen);
    end
    drain(ok);
    n_chk++;
    if ({b.if_err, b.if_rdata} !== {1'b1, 32'h0} || !ok) begin
      n_fail++; $display("FAIL oor_fetch_resp: got %b/%h, required 1/0", b.if_err, b.if_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] saved;
    bit [4:0] got;
    bit ok;
    saved = init_word(7);
    @(posedge clk); #1;
    gnt_log.delete();
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 32'd3;
    b.if_req = 1'b1; b.if_addr = 32'd4;
    for (int i = 0; i < 40 && gnt_log.size() < 3; i++) @(posedge clk);
    #1;
    b.d_we = 1'b1; b.d_addr = 32'd7; b.d_wdata = 32'h12345678;
    for (int i = 0; i < 40 && gnt_log.size() < 4; i++) @(posedge clk);
    #1;
    n_chk++;
    if (b.mem_wen !== 1'b1 || b.mem_addr !== 32'd7 || gnt_log.size() != 4) begin
      n_fail++; $display("FAIL mid_store_acc: got wen %b addr %h, required 1 7", b.mem_wen, b.mem_addr);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (b.mem_wen !== 1'b0) begin
      n_fail++; $display("FAIL mid_wen_async: got %b, required 0", b.mem_wen);
    end
    b.d_req = 1'b0; b.if_req = 1'b0; b.d_we = 1'b0;
    if_q.delete(); d_q.delete();
    @(negedge clk);
    n_chk++;
    if ({b.if_rvalid, b.d_rvalid, b.if_err, b.d_err, b.if_gnt, b.d_gnt} !== 6'b0 ||
        {b.if_rdata, b.d_rdata, b.mem_addr, b.mem_din} !== 128'h0) begin
      n_fail++; $display("FAIL mid_outputs_zero: got mem_addr %h d_rdata %h, required all 0", b.mem_addr, b.d_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (mem[7] !== saved) begin
      n_fail++; $display("FAIL mid_word7: got %h, required %h", mem[7], saved);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    gnt_log.delete();
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 32'd7;
    b.if_req = 1'b1; b.if_addr = 32'd6;
    for (int i = 0; i < 40 && gnt_log.size() < 5; i++) @(posedge clk);
    #1;
    b.d_req = 1'b0; b.if_req = 1'b0;
    got = '0;
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) got[4-i] = gnt_log[i];
    n_chk++;
    if (got !== 5'b11110) begin
      n_fail++; $display("FAIL mid_streak_cleared: got %b, required 11110", got);
    end
    drain(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL mid_drain: got pending, required empty"); end
  endtask

  task automatic test_back_to_back;
    int gc[4];
    int n;
    bit ok;
    @(posedge clk); #1;
    b.if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b.if_addr = 32'(8 + k);
      for (n = 0; n < 10; n++) begin
        @(negedge clk);
        if (b.if_gnt) break;
      end
      gc[k] = cyc;
      n_chk++;
      if (n == 10) begin
        n_fail++; $display("FAIL b2b_gnt_timeout: got no grant for %0d, required grant", k);
      end
      if (k > 0) begin
        n_chk++;
        if (gc[k] - gc[k-1] != 2 || b.if_rvalid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_spacing: got gap %0d rvalid %b, required 2 1", gc[k] - gc[k-1], b.if_rvalid);
        end
      end
      @(posedge clk); #1;
    end
    b.if_req = 1'b0;
    drain(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain: got pending, required empty"); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = init_word(i);
    b.if_addr = '0; b.d_addr = '0; b.d_wdata = '0;
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_fairness();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      n_fail++; $display("FAIL final_queues: got %0d/%0d pending, required 0/0", if_q.size(), d_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the fetch stage (IF port) and the load/store stage (D port).
- Arbitrates simultaneous requests and registers the winning access into the memory for one cycle.
- Captures read data and returns it with a one-cycle valid pulse.
- Data port has priority; a streak counter guarantees fetch forward progress.

Parameters:
- DEPTH, 32, number of 32-bit words in the memory; word-indexed addresses >= DEPTH are out of range.
- MAX_D_STREAK, 4, max consecutive D grants while if_req is pending before IF is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  32  fetch word index.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse: if_rdata/if_err valid.
- if_rdata  out  32  fetched word.
- if_err  out  1  fetch address out of range (qualified by if_rvalid).
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data word index.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  one-cycle pulse: load data, or store completion.
- d_rdata  out  32  load data; 0 for stores.
- d_err  out  1  data address out of range (qualified by d_rvalid).
- mem_addr  out  32  memory address (registered).
- mem_din  out  32  memory write data (registered).
- mem_wen  out  1  memory write enable.
- mem_dout  in  32  memory combinational read data.

Behaviour:
- FSM states: IDLE, ACC_IF, ACC_D.
- Grants are issued only in IDLE with rst high. ACC_* always returns to IDLE, so at most one access every 2 cycles.
- IDLE arbitration:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both asserted: grant IF if d_streak == MAX_D_STREAK, else grant D.
- Acceptance edge (req & gnt):
  - Latch mem_addr and mem_din from the winning port; mem_din = d_wdata for D, 0 for IF.
  - Latch the op kind (store/load) and the range check (addr >= DEPTH).
  - Go to ACC_IF or ACC_D.
- d_streak (4-bit) updates only at grant edges:
  - D grant while if_req high: increment, saturating at MAX_D_STREAK.
  - D grant with if_req low: clear.
  - IF grant: clear.
- ACC_* cycle:
  - mem_wen = 1 only in ACC_D with a latched store and the address in range. An out-of-range store never writes.
- Edge leaving ACC_*:
  - Load in range: rdata register <= mem_dout.
  - Store, or out of range: rdata register <= 0.
  - err <= latched range flag.
  - Winning port's rvalid <= 1.
- rvalid is high for exactly the one cycle after ACC_*, i.e. 2 cycles after the acceptance edge. The other port's rvalid stays 0.
- rdata/err hold their value until the next response on the same port.
- Requester may present a new request in the cycle after gnt; it waits for IDLE.
- rvalid and a new gnt can coincide in the same cycle.
- Reset (rst low, any time, including mid-access):
  - State goes to IDLE immediately.
  - mem_wen = 0 asynchronously; an access in flight is aborted and no write occurs.
  - Cleared to 0: mem_addr, mem_din, d_streak, if_rvalid, d_rvalid, if_rdata, d_rdata, if_err, d_err.
  - if_gnt = d_gnt = 0 while rst is low.
- Address widths:
  - Full 32-bit compare against DEPTH; no wrap-around.
  - mem_addr carries the full index even when out of range. The memory is never written out of range; read data is discarded.

Test Plan:
- Lone fetch: preload word0 = 0x00200513; if_req=1, if_addr=0 -> if_gnt same cycle; if_rvalid=1 with if_rdata=0x00200513, if_err=0 exactly 2 edges later; mem_wen never 1.
- Store then load: d_we=1, d_addr=5, d_wdata=0xDEADBEEF -> mem_wen=1 only in ACC_D with mem_addr=5; d_rvalid pulse with d_rdata=0. Then load addr 5 -> d_rdata=0xDEADBEEF.
- Contention/fairness: MAX_D_STREAK=4, both requests held continuously -> grant order D,D,D,D,IF,D,D,D,D,IF; no starvation of IF.
- Out of range: store to d_addr=32 (DEPTH=32) -> no mem_wen pulse, d_err=1 with d_rvalid. Fetch addr 0xFFFFFFFF -> if_err=1, if_rdata=0.
- Reset mid-access: assert rst low during ACC_D store to addr 7 -> mem_wen drops without a clock; word 7 unchanged. All outputs 0; after release, first grant occurs with d_streak=0.
- Back-to-back: if_req held high with new address after each gnt -> grants every 2 cycles; if_rvalid coincides with the next if_gnt; data returned in order.
